// File: rtl/tfr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tfr_pkg
// Description : Shared defaults and round-robin helper for the transfer-channel
//               arbiter. rr_pick returns the winning requester index and a
//               found flag for a mask of up to 16 requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package tfr_pkg;

  localparam int c_nin_default = 4;
  localparam int c_w_default   = 32;
  localparam int c_nin_max     = 16;

  // Requester-ID width for a given requester count (never below 1 bit)
  function automatic int lgnin(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of mask searching upward from last+1, wrapping modulo nin
  function automatic rr_pick_t rr_pick(input logic [c_nin_max-1:0] mask,
                                       input logic [3:0]           last,
                                       input int                   nin);
    rr_pick_t r;
    int       idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 1; i <= c_nin_max; i++) begin
      if (i <= nin) begin
        idx = (int'(last) + i) % nin;
        if (!r.found && mask[idx[3:0]]) begin
          r.found = 1'b1;
          r.idx   = 4'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_onehot.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_onehot
// Description : Combinational round-robin one-hot grant. Rotates the eligible
//               vector so the search start (last+1) sits at bit 0, isolates
//               the lowest set bit, then rotates the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_onehot #(
  parameter int NIN   = 4,
  parameter int LGNIN = 2
) (
  input  logic [NIN-1:0]   i_eligible,
  input  logic [LGNIN-1:0] i_last,
  output logic [NIN-1:0]   o_grant
);

  localparam logic [LGNIN-1:0] c_last_idx = LGNIN'(NIN - 1);

  logic [LGNIN-1:0] w_start;
  logic [NIN-1:0]   w_rot;
  logic [NIN-1:0]   w_iso;

  // Rotate right by the start index, keep lowest set bit, rotate back left
  always_comb begin
    w_start = (i_last == c_last_idx) ? '0 : i_last + 1'b1;
    w_rot   = NIN'({i_eligible, i_eligible} >> w_start);
    w_iso   = w_rot & (~w_rot + NIN'(1));
    o_grant = NIN'(({w_iso, w_iso} << w_start) >> NIN);
  end

endmodule
`default_nettype wire

// File: rtl/tfr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tfr_rr_arbiter
// Description : Round-robin arbiter feeding one clock-crossing value-transfer
//               channel from NIN same-domain valid/ready requesters. Holds the
//               registered output word, the winner ID and the RR pointer.
//               Optional macro TFR_RR_ARBITER_LOWPOWER_EN clears o_data/o_id
//               whenever the output goes idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tfr_rr_arbiter
  import tfr_pkg::*;
#(
  parameter  int NIN   = c_nin_default,
  parameter  int W     = c_w_default,
  localparam int LGNIN = lgnin(NIN)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NIN-1:0]   i_enable,
  input  logic [NIN-1:0]   i_valid,
  output logic [NIN-1:0]   o_ready,
  input  logic [NIN*W-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_data,
  output logic [LGNIN-1:0] o_id
);

  localparam logic [LGNIN-1:0] c_last_init = LGNIN'(NIN - 1);

  logic [NIN-1:0]       w_eligible;
  logic [NIN-1:0]       w_grant;
  logic                 w_load;
  rr_pick_t             w_pick;
  logic [LGNIN-1:0]     w_win_idx;
  logic                 w_unused;

  logic                 r_valid;
  logic [W-1:0]         r_data;
  logic [LGNIN-1:0]     r_id;
  logic [LGNIN-1:0]     r_last;

  rr_pick_onehot #(
    .NIN   (NIN),
    .LGNIN (LGNIN)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_grant    (w_grant)
  );

  // Eligibility, load condition, winner index and gated handshake
  always_comb begin
    w_eligible = i_valid & i_enable;
    w_load     = !r_valid || i_ready;
    w_pick     = rr_pick(c_nin_max'(w_eligible), 4'(r_last), NIN);
    w_win_idx  = LGNIN'(w_pick.idx);
    w_unused   = &{1'b0, w_pick.idx};
    // Reset discards any pending word, so no requester sees a handshake
    o_ready    = (w_load && !i_reset) ? w_grant : '0;
  end

  // Output register and pointer; pointer only moves on an actual grant
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= c_last_init;
    end else if (w_load) begin
      if (w_pick.found) begin
        r_valid <= 1'b1;
        r_data  <= i_data[w_win_idx*W +: W];
        r_id    <= w_win_idx;
        r_last  <= w_win_idx;
      end else begin
        r_valid <= 1'b0;
`ifdef TFR_RR_ARBITER_LOWPOWER_EN
        r_data  <= '0;
        r_id    <= '0;
`else
        r_data  <= r_data;
        r_id    <= r_id;
`endif
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_tfr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tfr_rr_arbiter
// Description : Directed self-checking bench for tfr_rr_arbiter (NIN=4, W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tfr_rr_arbiter;

  localparam int NIN = 4;
  localparam int W   = 32;

  logic             i_clk;
  logic             i_reset;
  logic [NIN-1:0]   i_enable;
  logic [NIN-1:0]   i_valid;
  logic [NIN-1:0]   o_ready;
  logic [NIN*W-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [W-1:0]     o_data;
  logic [1:0]       o_id;

  int n_checks   = 0;
  int n_failures = 0;

  tfr_rr_arbiter #(
    .NIN (NIN),
    .W   (W)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_id     (o_id)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    i_data = {d3, d2, d1, d0};
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] id);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    check({tag, ".data"},  o_data,       d);
    check({tag, ".id"},    32'(o_id),    32'(id));
  endtask

  logic [31:0] idle_data;
  logic [1:0]  idle_id;

  initial begin
    i_reset  = 1'b1;
    i_enable = 4'hF;
    i_valid  = 4'h0;
    i_ready  = 1'b0;
    set_data(32'h100, 32'h101, 32'h102, 32'h103);
    step();
    step();
    i_reset = 1'b0;
    check_out("reset", 1'b0, 32'h0, 2'd0);

    // Fairness: all valid, grants 0,1,2,3,0
    i_valid = 4'hF;
    i_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check($sformatf("fair%0d.ready", n), 32'(o_ready), 32'(4'b0001 << (n % 4)));
      step();
      check_out($sformatf("fair%0d", n), 1'b1, 32'h100 + 32'(n % 4), 2'(n % 4));
    end

    // Drain with nothing eligible
    i_valid = 4'h0;
    #1;
    check("drain.ready", 32'(o_ready), 32'h0);
    step();
`ifdef TFR_RR_ARBITER_LOWPOWER_EN
    idle_data = 32'h0;
    idle_id   = 2'd0;
`else
    idle_data = 32'h100;
    idle_id   = 2'd0;
`endif
    check_out("drain", 1'b0, idle_data, idle_id);

    // Back-pressure: req1 word held for 5 cycles
    set_data(32'h100, 32'hAA, 32'h102, 32'h103);
    i_valid = 4'b0010;
    i_ready = 1'b0;
    #1;
    check("bp.ready0", 32'(o_ready), 32'b0010);
    step();
    check_out("bp.load", 1'b1, 32'hAA, 2'd1);
    for (int n = 0; n < 5; n++) begin
      check($sformatf("bp%0d.ready", n), 32'(o_ready), 32'h0);
      step();
      check_out($sformatf("bp%0d", n), 1'b1, 32'hAA, 2'd1);
    end
    // Release: pointer stayed at 1, so req2 wins next
    i_valid = 4'hF;
    i_ready = 1'b1;
    #1;
    check("bp.rel.ready", 32'(o_ready), 32'b0100);
    step();
    check_out("bp.rel", 1'b1, 32'h102, 2'd2);

    // Enable mask 0101: grants 0,2,0,2
    set_data(32'h100, 32'h101, 32'h102, 32'h103);
    i_enable = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      #1;
      check($sformatf("mask%0d.ready", n), 32'(o_ready), (n % 2 == 0) ? 32'b0001 : 32'b0100);
      step();
      check_out($sformatf("mask%0d", n), 1'b1, (n % 2 == 0) ? 32'h100 : 32'h102,
                (n % 2 == 0) ? 2'd0 : 2'd2);
    end

    // Sparse / wrap: bring pointer to 3, then req2, then req0
    i_enable = 4'hF;
    i_valid  = 4'b1000;
    #1;
    check("wrap.r3.ready", 32'(o_ready), 32'b1000);
    step();
    check_out("wrap.r3", 1'b1, 32'h103, 2'd3);
    i_valid = 4'b0100;
    #1;
    check("wrap.r2.ready", 32'(o_ready), 32'b0100);
    step();
    check_out("wrap.r2", 1'b1, 32'h102, 2'd2);
    i_valid = 4'b0001;
    #1;
    check("wrap.r0.ready", 32'(o_ready), 32'b0001);
    step();
    check_out("wrap.r0", 1'b1, 32'h100, 2'd0);
    i_valid = 4'b0000;
    step();
`ifdef TFR_RR_ARBITER_LOWPOWER_EN
    idle_data = 32'h0;
`else
    idle_data = 32'h100;
`endif
    check_out("wrap.idle", 1'b0, idle_data, 2'd0);

    // Reset mid-operation with a held word
    set_data(32'h100, 32'hAA, 32'h102, 32'h103);
    i_valid = 4'b0010;
    i_ready = 1'b0;
    step();
    check_out("rst.held", 1'b1, 32'hAA, 2'd1);
    i_reset = 1'b1;
    i_ready = 1'b1;
    i_valid = 4'hF;
    #1;
    check("rst.ready", 32'(o_ready), 32'h0);
    step();
    i_reset = 1'b0;
    check_out("rst.after", 1'b0, 32'h0, 2'd0);
    #1;
    check("rst.first.ready", 32'(o_ready), 32'b0001);
    step();
    check_out("rst.first", 1'b1, 32'h100, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
`default_nettype wire
